prec_mac_acc: RTL and testbench

Precision-scalable, parametrised multiply-accumulate engine with a streaming handshake and grouped accumulation. Each accepted beat multiplies a signed activation `a` by a weight `w`. `w` is treated as 1, 2 or 4 signed sub-words depending on the precision mode, and each product is accumulated into its own slice of one `ACC_W`-bit accumulator. After a programmed number of beats the block presents the result with per-lane saturation flags and holds it until the consumer takes it. The block sits between the activation/weight feeder and the result write-back stage of the MAC array.

---
 rtl/prec_mac_acc.sv | 159 +++++++++++++++
 tb/tb_prec_mac_acc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/prec_mac_acc.sv
// prec_mac_acc: precision-scalable MAC with grouped accumulation.
// Weight is split into 1/2/4 signed lanes, each saturating into its own slice.
module prec_mac_acc #(
  parameter int AW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 56,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    a,
  input  logic [WW-1:0]    w,
  input  logic [1:0]       prec,
  input  logic [LEN_W-1:0] len_m1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [3:0]       sat
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state;
  logic             rdy;
  logic [1:0]       prec_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   cnt;
  logic [ACC_W-1:0] acc;
  logic             first;
  logic             beat;
  logic [1:0]       mode;
  logic [1:0]       sel;
  logic [ACC_W-1:0] nsum;
  logic [3:0]       nov;
  logic [ACC_W-1:0] nx [3];
  logic [3:0]       ov [3];
  logic signed [AW-1:0] sa;

  assign in_ready = rstn & rdy;
  assign beat     = in_valid & in_ready;
  assign first    = state == IDLE;
  assign sa       = a;
  assign acc_out  = acc;

  // First beat uses live prec; later beats use the latched one.
  assign mode = first ? prec : prec_q;

  always_comb begin
    sel = 2'd0;
    unique case (1'b1)
      mode == 2'b01: sel = 2'd1;
      mode == 2'b10: sel = 2'd2;
      default:       sel = 2'd0;
    endcase
  end

  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int K = 1 << m;
    localparam int L = ACC_W / K;
    localparam int Q = WW / K;
    localparam int P = AW + Q;
    logic [ACC_W-1:0] n;
    logic [K-1:0]     o;
    for (genvar i = 0; i < K; i++) begin : g_lane
      logic signed [Q-1:0] wi;
      logic signed [P-1:0] p;
      logic signed [L-1:0] pe;
      logic signed [L-1:0] cur;
      logic signed [L:0]   s;
      assign wi  = w[i*Q +: Q];
      assign p   = P'(sa) * P'(wi);
      assign pe  = L'(p);
      assign cur = acc[i*L +: L];
      assign s   = (L+1)'(cur) + (L+1)'(pe);
      assign o[i] = !first && (s[L] != s[L-1]);
      // Overflow clamps toward the sign of the wide sum.
      assign n[i*L +: L] = first ? pe :
        o[i] ? {s[L], {(L-1){~s[L]}}} :
        s[L-1:0];
    end
    assign nx[m] = n;
    assign ov[m] = 4'(o);
  end

  always_comb begin
    nsum = nx[0];
    nov  = ov[0];
    unique case (1'b1)
      sel == 2'd1: begin
        nsum = nx[1];
        nov  = ov[1];
      end
      sel == 2'd2: begin
        nsum = nx[2];
        nov  = ov[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      out_valid <= 1'b0;
      acc       <= '0;
      sat       <= '0;
      cnt       <= '0;
      prec_q    <= '0;
      len_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (beat) begin
            prec_q <= prec;
            len_q  <= len_m1;
            acc    <= nsum;
            sat    <= '0;
            cnt    <= (LEN_W+1)'(1);
            if (len_m1 == '0) begin
              state     <= DONE;
              rdy       <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc <= nsum;
            sat <= sat | nov;
            cnt <= cnt + 1'b1;
            if (cnt == {1'b0, len_q}) begin
              state     <= DONE;
              rdy       <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prec_mac_acc.sv
// tb_prec_mac_acc: directed bench with hand-computed expectations.
// Covers lane modes, saturation, backpressure, reset and prec latching.
module tb_prec_mac_acc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  w;
  logic [1:0]  prec;
  logic [7:0]  len_m1;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] acc_out;
  logic [3:0]  sat;

  int checks = 0;
  int errors = 0;

  prec_mac_acc dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .w         (w),
    .prec      (prec),
    .len_m1    (len_m1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] av,
                      input logic [7:0] wv,
                      input logic [1:0] pv,
                      input logic [7:0] lv);
    in_valid = 1'b1;
    a        = av;
    w        = wv;
    prec     = pv;
    len_m1   = lv;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    w         = '0;
    prec      = '0;
    len_m1    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_acc", 64'(acc_out), 64'h0);
    chk("rst_sat", 64'(sat), 64'h0);
    chk("rst_ov", 64'(out_valid), 64'h0);
    chk("rst_ir", 64'(in_ready), 64'h0);
    rstn = 1'b1;
    #1;
    chk("post_rst_ir", 64'(in_ready), 64'h1);

    // mode 00, two beats
    beat(8'd127, 8'd127, 2'b00, 8'd1);
    chk("m0_b1_acc", 64'(acc_out), 64'd16129);
    chk("m0_b1_ov", 64'(out_valid), 64'h0);
    beat(8'h80, 8'h80, 2'b00, 8'd1);
    chk("m0_acc", 64'(acc_out), 64'd32513);
    chk("m0_sat", 64'(sat), 64'h0);
    chk("m0_ov", 64'(out_valid), 64'h1);
    chk("m0_ir", 64'(in_ready), 64'h0);
    drain();
    chk("m0_drain_ov", 64'(out_valid), 64'h0);
    chk("m0_drain_ir", 64'(in_ready), 64'h1);
    chk("m0_hold_acc", 64'(acc_out), 64'd32513);

    // mode 01, single beat
    beat(8'd127, 8'h78, 2'b01, 8'd0);
    chk("m1_acc", 64'(acc_out), 64'(56'h0000379_FFFFC08));
    chk("m1_sat", 64'(sat), 64'h0);
    chk("m1_ov", 64'(out_valid), 64'h1);
    drain();

    // mode 10, single beat
    beat(8'h80, 8'b00011011, 2'b10, 8'd0);
    chk("m2_acc", 64'(acc_out),
        64'({14'h0000, 14'h3F80, 14'h0100, 14'h0080}));
    chk("m2_sat", 64'(sat), 64'h0);
    drain();

    // saturation: 32 x (+256) per lane
    for (int i = 0; i < 32; i++) begin
      beat(8'h80, 8'hAA, 2'b10, 8'd31);
      if (i == 30) begin
        chk("sat_b31_acc", 64'(acc_out), 64'({4{14'd7936}}));
        chk("sat_b31_ov", 64'(out_valid), 64'h0);
      end
    end
    chk("sat_acc", 64'(acc_out), 64'({4{14'h1FFF}}));
    chk("sat_flags", 64'(sat), 64'hF);
    chk("sat_ov", 64'(out_valid), 64'h1);

    // backpressure with offered beats
    in_valid = 1'b1;
    a        = 8'd5;
    w        = 8'd5;
    prec     = 2'b00;
    len_m1   = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ov", 64'(out_valid), 64'h1);
      chk("bp_ir", 64'(in_ready), 64'h0);
      chk("bp_acc", 64'(acc_out), 64'({4{14'h1FFF}}));
      chk("bp_sat", 64'(sat), 64'hF);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_rel_ov", 64'(out_valid), 64'h0);
    chk("bp_rel_ir", 64'(in_ready), 64'h1);
    chk("bp_rel_acc", 64'(acc_out), 64'({4{14'h1FFF}}));
    beat(8'd1, 8'd1, 2'b00, 8'd0);
    chk("next_acc", 64'(acc_out), 64'd1);
    chk("next_sat", 64'(sat), 64'h0);
    chk("next_ov", 64'(out_valid), 64'h1);
    drain();

    // reset mid-group
    beat(8'd2, 8'd3, 2'b00, 8'd3);
    beat(8'd2, 8'd3, 2'b00, 8'd3);
    chk("mid_acc", 64'(acc_out), 64'd12);
    rstn = 1'b0;
    tick();
    chk("mrst_acc", 64'(acc_out), 64'h0);
    chk("mrst_ov", 64'(out_valid), 64'h0);
    chk("mrst_ir", 64'(in_ready), 64'h0);
    rstn = 1'b1;
    #1;
    chk("mrst_rel_ir", 64'(in_ready), 64'h1);

    // prec and len_m1 latched on the first beat only
    beat(8'd1, 8'h55, 2'b10, 8'd3);
    beat(8'd1, 8'h55, 2'b00, 8'd0);
    chk("lat_b2_ov", 64'(out_valid), 64'h0);
    beat(8'd1, 8'h55, 2'b01, 8'd0);
    chk("lat_b3_ov", 64'(out_valid), 64'h0);
    beat(8'd1, 8'h55, 2'b11, 8'd0);
    chk("lat_ov", 64'(out_valid), 64'h1);
    chk("lat_acc", 64'(acc_out), 64'({4{14'd4}}));
    chk("lat_sat", 64'(sat), 64'h0);
    drain();
    chk("end_ov", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
